// File: rtl/seven_seg_pkg.sv
// Shared definitions for the multiplexed seven-segment display driver.
// Contents:
//   - legal parameter ranges for seven_seg_mux
//   - SEG_OFF, the all-dark active-low segment pattern
//   - SEG_TABLE, the 16-entry hex glyph table (bit 0 = segment a ... bit 6 = g,
//     active-low)
//   - slot_state_t, the per-slot GUARD/DRIVE phase
//   - hex_to_seg(), a table lookup helper
package seven_seg_pkg;

  localparam int MIN_DIGITS      = 1;
  localparam int MAX_DIGITS      = 8;
  localparam int MIN_REFRESH_CYC = 4;
  localparam int MIN_GUARD_CYC   = 1;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Listed from index 15 (F) down to index 0 (0).
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  typedef enum logic {
    ST_GUARD,
    ST_DRIVE
  } slot_state_t;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    return SEG_TABLE[nib];
  endfunction

endpackage

// File: rtl/seg_decode.sv
// Combinational hex-to-seven-segment decoder, usable on its own.
// Ports:
//   nibble  in  4  hex value to display
//   blank   in  1  1 = force all segments dark
//   seg     out 7  segments a..g in [0]..[6], active-low
module seg_decode
  import seven_seg_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_OFF;
    if (!blank) begin
      seg = hex_to_seg(nibble);
    end
  end

endmodule

// File: rtl/seven_seg_mux.sv
// Time-multiplexed driver for a common-anode style seven-segment display.
// Each digit owns a slot of REFRESH_CYC clocks; the first GUARD_CYC clocks of
// every slot keep all digits dark so the previous digit cannot ghost onto the
// next one. Inputs are captured into shadow registers on load, and a slot
// latches its digit's shadow values once at slot start so a digit never tears.
// Optional feature: define SEVEN_SEG_LZS_EN to blank leading-zero digits.
// Parameters:
//   NUM_DIGITS   1..8, number of digits
//   REFRESH_CYC  >= 4, clocks per digit slot
//   GUARD_CYC    1..REFRESH_CYC-2, dark clocks at the start of each slot
// Ports:
//   clk    in  1             system clock, rising edge
//   rst    in  1             asynchronous active-high reset
//   data   in  4*NUM_DIGITS  hex nibbles, digit 0 in [3:0]
//   dp_in  in  NUM_DIGITS    per-digit decimal point, 1 = lit
//   blank  in  NUM_DIGITS    per-digit blank, 1 = dark
//   load   in  1             capture data/dp_in/blank into shadow registers
//   seg    out 7             segments a..g, active-low, registered
//   dp     out 1             decimal point, active-low, registered
//   an     out NUM_DIGITS    digit enables, active-low, registered
//   frame  out 1             one-cycle pulse per completed scan, registered
module seven_seg_mux
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_CYC = 50000,
  parameter int GUARD_CYC   = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] data,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank,
  input  logic                    load,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame
);

  localparam int CNT_W = $clog2(REFRESH_CYC);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(REFRESH_CYC - 1);
  localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  logic [4*NUM_DIGITS-1:0] data_sh;
  logic [NUM_DIGITS-1:0]   dp_sh;
  logic [NUM_DIGITS-1:0]   blank_sh;

  logic [3:0] slot_nib;
  logic       slot_dp;
  logic       slot_blank;

  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] idx_next;
  logic             wrap;

  logic [3:0] copy_nib;
  logic       copy_dp;
  logic       copy_blank;
  logic [NUM_DIGITS-1:0] lz_mask;

  slot_state_t state;
  slot_state_t state_next;

  logic [6:0]            dec_seg;
  logic [6:0]            seg_d;
  logic                  dp_d;
  logic [NUM_DIGITS-1:0] an_d;
  logic                  frame_d;

  assign wrap = (cnt == CNT_LAST);

  // Digit that the next slot will show.
  always_comb begin
    idx_next = idx + IDX_W'(1);
    if (idx == IDX_LAST) begin
      idx_next = '0;
    end
  end

`ifdef SEVEN_SEG_LZS_EN
  // Walk down from the top digit; everything zero with no dp is suppressed
  // until the first significant digit. Digit 0 is never suppressed.
  always_comb begin
    logic leading;
    lz_mask = '0;
    leading = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      if (leading && (data_sh[4*k +: 4] == 4'h0) && !dp_sh[k]) begin
        lz_mask[k] = 1'b1;
      end else begin
        leading = 1'b0;
      end
    end
  end
`else
  assign lz_mask = '0;
`endif

  // Shadow values for the digit about to take the display.
  always_comb begin
    copy_nib   = 4'h0;
    copy_dp    = 1'b0;
    copy_blank = 1'b1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_next == IDX_W'(k)) begin
        copy_nib   = data_sh[4*k +: 4];
        copy_dp    = dp_sh[k];
        copy_blank = blank_sh[k] | lz_mask[k];
      end
    end
  end

  // Shadow registers; the slot copy below reads their pre-load values, so a
  // load coinciding with slot start only takes effect in a later slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_sh  <= '0;
      dp_sh    <= '0;
      blank_sh <= '1;
    end else if (load) begin
      data_sh  <= data;
      dp_sh    <= dp_in;
      blank_sh <= blank;
    end
  end

  // Slot timing and the once-per-slot digit capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      idx        <= '0;
      slot_nib   <= 4'h0;
      slot_dp    <= 1'b0;
      slot_blank <= 1'b0;
    end else if (wrap) begin
      cnt        <= '0;
      idx        <= idx_next;
      slot_nib   <= copy_nib;
      slot_dp    <= copy_dp;
      slot_blank <= copy_blank;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  seg_decode u_seg_decode (
    .nibble (slot_nib),
    .blank  (slot_blank),
    .seg    (dec_seg)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_GUARD;
    end else begin
      state <= state_next;
    end
  end

  // Phase tracking plus the output values for the current cnt/idx; the
  // registers below present them one clock later.
  always_comb begin
    state_next = state;
    if (wrap) begin
      state_next = ST_GUARD;
    end else if (cnt == GUARD_LAST) begin
      state_next = ST_DRIVE;
    end

    seg_d   = SEG_OFF;
    dp_d    = 1'b1;
    an_d    = '1;
    frame_d = wrap && (idx == IDX_LAST);

    if ((state == ST_DRIVE) && !slot_blank) begin
      seg_d = dec_seg;
      dp_d  = ~slot_dp;
      for (int k = 0; k < NUM_DIGITS; k++) begin
        if (idx == IDX_W'(k)) begin
          an_d[k] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg   <= SEG_OFF;
      dp    <= 1'b1;
      an    <= '1;
      frame <= 1'b0;
    end else begin
      seg   <= seg_d;
      dp    <= dp_d;
      an    <= an_d;
      frame <= frame_d;
    end
  end

endmodule

// File: tb/tb_seven_seg_mux.sv
// Self-checking bench for seven_seg_mux (NUM_DIGITS=4, REFRESH_CYC=8,
// GUARD_CYC=2). A reference model tracks elapsed cycles since reset and
// derives slot position and digit with plain arithmetic.
module tb_seven_seg_mux;

  localparam int N     = 4;
  localparam int R     = 8;
  localparam int G     = 2;
  localparam int FRAME = N * R;

  logic        clk;
  logic        rst;
  logic [15:0] data;
  logic [3:0]  dp_in;
  logic [3:0]  blank;
  logic        load;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame;

  seven_seg_mux #(
    .NUM_DIGITS  (N),
    .REFRESH_CYC (R),
    .GUARD_CYC   (G)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .data  (data),
    .dp_in (dp_in),
    .blank (blank),
    .load  (load),
    .seg   (seg),
    .dp    (dp),
    .an    (an),
    .frame (frame)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int passed = 0;

  logic [6:0]  hex_lut [16];
  int          m_n;
  logic [15:0] m_data;
  logic [3:0]  m_dp;
  logic [3:0]  m_blank;
  logic [3:0]  m_nib;
  logic        m_sdp;
  logic        m_sblank;
  logic [12:0] exp_out;

  task automatic model_reset();
    m_n      = 0;
    m_data   = 16'h0;
    m_dp     = 4'h0;
    m_blank  = 4'hF;
    m_nib    = 4'h0;
    m_sdp    = 1'b0;
    m_sblank = 1'b0;
    exp_out  = {7'h7F, 1'b1, 4'hF, 1'b0};
  endtask

  // Expected {seg, dp, an, frame} produced from the cycle at position p.
  function automatic logic [12:0] model_out(int p);
    int         c;
    int         d;
    logic [6:0] s;
    logic       o;
    logic [3:0] a;
    c = p % R;
    d = (p / R) % N;
    s = 7'h7F;
    o = 1'b1;
    a = 4'hF;
    if (c >= G && !m_sblank) begin
      s    = hex_lut[m_nib];
      o    = ~m_sdp;
      a[d] = 1'b0;
    end
    return {s, o, a, (c == R - 1) && (d == N - 1)};
  endfunction

  // Drive one cycle of inputs, advance the model, return at the next negedge.
  task automatic step(input logic ld, input logic [15:0] d,
                      input logic [3:0] dpi, input logic [3:0] bl);
    int dg;
    load  = ld;
    data  = d;
    dp_in = dpi;
    blank = bl;
    @(posedge clk);
    exp_out = model_out(m_n);
    m_n++;
    if (m_n % R == 0) begin
      dg       = (m_n / R) % N;
      m_nib    = m_data[4*dg +: 4];
      m_sdp    = m_dp[dg];
      m_sblank = m_blank[dg];
`ifdef SEVEN_SEG_LZS_EN
      if (dg > 0 && (m_data >> (4 * dg)) == 16'h0 && (m_dp >> dg) == 4'h0) begin
        m_sblank = 1'b1;
      end
`endif
    end
    if (ld) begin
      m_data  = d;
      m_dp    = dpi;
      m_blank = bl;
    end
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic idle();
    step(1'b0, 16'h0, 4'h0, 4'h0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    load  = 1'b0;
    data  = 16'h0;
    dp_in = 4'h0;
    blank = 4'h0;
    repeat (3) @(negedge clk);
    checks++;
    if ({seg, dp, an, frame} !== {7'h7F, 1'b1, 4'hF, 1'b0}) begin
      $display("[TB] FAIL reset_hold got=%h exp=%h", {seg, dp, an, frame}, {7'h7F, 1'b1, 4'hF, 1'b0});
    end else passed++;
    rst = 1'b0;
    model_reset();
    for (int i = 1; i <= 24; i++) begin
      idle();
      checks++;
      if ({seg, dp, an, frame} !== exp_out) begin
        $display("[TB] FAIL reset_model cyc=%0d got=%h exp=%h", m_n, {seg, dp, an, frame}, exp_out);
      end else passed++;
      if (i == 3) begin
        checks++;
        if (an !== 4'b1110) begin
          $display("[TB] FAIL reset_first_drive an=%b exp=1110", an);
        end else passed++;
      end
      if (i > 8) begin
        checks++;
        if (an !== 4'hF) begin
          $display("[TB] FAIL reset_dark_until_load cyc=%0d an=%b exp=1111", m_n, an);
        end else passed++;
      end
    end
  endtask

  task automatic test_scan();
    int last_frame;
    int nframes;
    do_reset();
    step(1'b1, 16'h1234, 4'h0, 4'h0);
    last_frame = -1;
    nframes    = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      idle();
      checks++;
      if ({seg, dp, an, frame} !== exp_out) begin
        $display("[TB] FAIL scan_model cyc=%0d got=%h exp=%h", m_n, {seg, dp, an, frame}, exp_out);
      end else passed++;
      if (frame === 1'b1) begin
        nframes++;
        if (last_frame >= 0) begin
          checks++;
          if (m_n - last_frame != FRAME) begin
            $display("[TB] FAIL scan_frame_period got=%0d exp=%0d", m_n - last_frame, FRAME);
          end else passed++;
        end
        last_frame = m_n;
      end
      if (i >= FRAME && an === 4'b1110) begin
        checks++;
        if (seg !== 7'b0011001) begin
          $display("[TB] FAIL scan_digit0 seg=%b exp=0011001", seg);
        end else passed++;
      end
      if (i >= FRAME && an === 4'b0111) begin
        checks++;
        if (seg !== 7'b1111001) begin
          $display("[TB] FAIL scan_digit3 seg=%b exp=1111001", seg);
        end else passed++;
      end
    end
    checks++;
    if (nframes != 2) begin
      $display("[TB] FAIL scan_frame_count got=%0d exp=2", nframes);
    end else passed++;
  endtask

  task automatic test_blank_dp();
    step(1'b1, 16'h1234, 4'b0001, 4'b0010);
    for (int i = 0; i < 2 * FRAME; i++) begin
      idle();
      checks++;
      if ({seg, dp, an, frame} !== exp_out) begin
        $display("[TB] FAIL blank_dp_model cyc=%0d got=%h exp=%h", m_n, {seg, dp, an, frame}, exp_out);
      end else passed++;
      if (i >= FRAME && an !== 4'hF) begin
        checks++;
        if (an === 4'b1101 || dp !== (an === 4'b1110 ? 1'b0 : 1'b1)) begin
          $display("[TB] FAIL blank_dp_lit an=%b dp=%b exp_dp=%b", an, dp, (an === 4'b1110 ? 1'b0 : 1'b1));
        end else passed++;
      end
    end
  endtask

  task automatic test_tear_free();
    step(1'b1, 16'h1234, 4'h0, 4'h0);
    for (int i = 0; i < 3 * FRAME && !(m_n % FRAME == 5 && m_n > 2 * FRAME); i++) begin
      idle();
      checks++;
      if ({seg, dp, an, frame} !== exp_out) begin
        $display("[TB] FAIL tear_align cyc=%0d got=%h exp=%h", m_n, {seg, dp, an, frame}, exp_out);
      end else passed++;
    end
    checks++;
    if (m_n % FRAME != 5) begin
      $display("[TB] FAIL tear_align_pos got=%0d exp=5", m_n % FRAME);
    end else passed++;
    step(1'b1, 16'h1239, 4'h0, 4'h0);
    for (int k = 1; k <= 30; k++) begin
      idle();
      checks++;
      if ({seg, dp, an, frame} !== exp_out) begin
        $display("[TB] FAIL tear_model cyc=%0d got=%h exp=%h", m_n, {seg, dp, an, frame}, exp_out);
      end else passed++;
      if (k <= 2 || k == 30) begin
        checks++;
        if (seg !== (k == 30 ? 7'b0010000 : 7'b0011001) || an !== 4'b1110) begin
          $display("[TB] FAIL tear_seg k=%0d seg=%b an=%b", k, seg, an);
        end else passed++;
      end
    end
  endtask

  task automatic test_lzs();
    logic [6:0] es;
    step(1'b1, 16'h0050, 4'h0, 4'h0);
    for (int i = 0; i < 2 * FRAME; i++) begin
      idle();
      checks++;
      if ({seg, dp, an, frame} !== exp_out) begin
        $display("[TB] FAIL lzs_model cyc=%0d got=%h exp=%h", m_n, {seg, dp, an, frame}, exp_out);
      end else passed++;
      if (i >= FRAME && an !== 4'hF) begin
        case (an)
          4'b1110: es = 7'b1000000;
          4'b1101: es = 7'b0010010;
`ifdef SEVEN_SEG_LZS_EN
          default: es = 7'h7F;
`else
          default: es = 7'b1000000;
`endif
        endcase
        checks++;
        if (seg !== es) begin
          $display("[TB] FAIL lzs_digit an=%b seg=%b exp=%b", an, seg, es);
        end else passed++;
      end
    end
  endtask

  task automatic test_mid_reset();
    step(1'b1, 16'h1234, 4'h0, 4'h0);
    for (int i = 0; i < 2 * FRAME && !(m_n % FRAME == 21 && m_n > FRAME); i++) begin
      idle();
      checks++;
      if ({seg, dp, an, frame} !== exp_out) begin
        $display("[TB] FAIL mid_reset_pre cyc=%0d got=%h exp=%h", m_n, {seg, dp, an, frame}, exp_out);
      end else passed++;
    end
    checks++;
    if (an !== 4'b1011) begin
      $display("[TB] FAIL mid_reset_at_idx2 an=%b exp=1011", an);
    end else passed++;
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({seg, dp, an, frame} !== {7'h7F, 1'b1, 4'hF, 1'b0}) begin
      $display("[TB] FAIL mid_reset_async got=%h exp=%h", {seg, dp, an, frame}, {7'h7F, 1'b1, 4'hF, 1'b0});
    end else passed++;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int i = 1; i <= 4; i++) begin
      idle();
      checks++;
      if ({seg, dp, an, frame} !== exp_out) begin
        $display("[TB] FAIL mid_reset_post cyc=%0d got=%h exp=%h", m_n, {seg, dp, an, frame}, exp_out);
      end else passed++;
      if (i == 3) begin
        checks++;
        if (an !== 4'b1110) begin
          $display("[TB] FAIL mid_reset_first_drive an=%b exp=1110", an);
        end else passed++;
      end
    end
  endtask

  task automatic test_random();
    logic        ld;
    logic [15:0] d;
    logic [3:0]  p;
    logic [3:0]  b;
    for (int i = 0; i < 400; i++) begin
      ld = ($urandom_range(0, 7) == 0);
      d  = 16'($urandom);
      p  = 4'($urandom);
      b  = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
      if ($urandom_range(0, 3) == 0) d[15:8] = 8'h00;
      step(ld, d, p, b);
      checks++;
      if ({seg, dp, an, frame} !== exp_out) begin
        $display("[TB] FAIL random_model cyc=%0d got=%h exp=%h", m_n, {seg, dp, an, frame}, exp_out);
      end else passed++;
    end
  endtask

  initial begin
    hex_lut[0]  = 7'b1000000; hex_lut[1]  = 7'b1111001;
    hex_lut[2]  = 7'b0100100; hex_lut[3]  = 7'b0110000;
    hex_lut[4]  = 7'b0011001; hex_lut[5]  = 7'b0010010;
    hex_lut[6]  = 7'b0000010; hex_lut[7]  = 7'b1111000;
    hex_lut[8]  = 7'b0000000; hex_lut[9]  = 7'b0010000;
    hex_lut[10] = 7'b0001000; hex_lut[11] = 7'b0000011;
    hex_lut[12] = 7'b1000110; hex_lut[13] = 7'b0100001;
    hex_lut[14] = 7'b0000110; hex_lut[15] = 7'b0001110;
    model_reset();

    test_reset();
    test_scan();
    test_blank_dp();
    test_tear_free();
    test_lzs();
    test_mid_reset();
    test_random();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
